// File: rtl/psum_accum.sv
// Four-lane partial-sum accumulator: each lane sums acc_len+1 unsigned products
// into a 24-bit psum and pulses dv_psum for one cycle when the window closes or flushes.
module psum_accum #(
    parameter int LANES = 4,
    parameter int PW    = 16,
    parameter int SW    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            acc_len,
    input  logic                  flush,
    input  logic [LANES-1:0]      dv_prod,
    input  logic [LANES*PW-1:0]   prod,
    output logic [LANES*SW-1:0]   psum,
    output logic [LANES-1:0]      dv_psum
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SW-1:0] acc_q, acc_d;
            logic [7:0]    cnt_q, cnt_d;
            logic [7:0]    len_q, len_d;
            logic          busy_q, busy_d;
            logic [SW-1:0] psum_q, psum_d;
            logic          dv_q, dv_d;
            logic [SW-1:0] prod_ext;
            logic [SW-1:0] sum;

            assign prod_ext = {{(SW-PW){1'b0}}, prod[gi*PW +: PW]};
            // 256 x 0xFFFF still fits in 24 bits, so the adder never wraps.
            assign sum      = acc_q + prod_ext;

            always_comb begin
                acc_d  = acc_q;
                cnt_d  = cnt_q;
                len_d  = len_q;
                busy_d = busy_q;
                psum_d = psum_q;
                dv_d   = 1'b0;
                if (!busy_q) begin
                    if (dv_prod[gi]) begin
                        len_d = acc_len;
                        if (acc_len == 8'd0 || flush) begin
                            psum_d = prod_ext;
                            dv_d   = 1'b1;
                            acc_d  = '0;
                            cnt_d  = 8'd0;
                        end else begin
                            acc_d  = prod_ext;
                            cnt_d  = 8'd1;
                            busy_d = 1'b1;
                        end
                    end
                end else if (dv_prod[gi]) begin
                    // cnt counts terms already held, so cnt==len means this beat is the last.
                    if (cnt_q == len_q || flush) begin
                        psum_d = sum;
                        dv_d   = 1'b1;
                        acc_d  = '0;
                        cnt_d  = 8'd0;
                        busy_d = 1'b0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (flush) begin
                    psum_d = acc_q;
                    dv_d   = 1'b1;
                    acc_d  = '0;
                    cnt_d  = 8'd0;
                    busy_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q  <= '0;
                    cnt_q  <= 8'd0;
                    len_q  <= 8'd0;
                    busy_q <= 1'b0;
                    psum_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                    len_q  <= len_d;
                    busy_q <= busy_d;
                    psum_q <= psum_d;
                    dv_q   <= dv_d;
                end
            end

            assign psum[gi*SW +: SW] = psum_q;
            assign dv_psum[gi]       = dv_q;
        end
    endgenerate

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: a window-level model checked every cycle, plus
// directed scenarios whose emitted sums are compared against hand-computed values.
module tb_psum_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  acc_len = 8'd0;
    logic        flush = 1'b0;
    logic [3:0]  dv_prod = 4'd0;
    logic [63:0] prod = 64'd0;
    logic [95:0] psum;
    logic [3:0]  dv_psum;

    int checks = 0;
    int errors = 0;

    psum_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_len (acc_len),
        .flush   (flush),
        .dv_prod (dv_prod),
        .prod    (prod),
        .psum    (psum),
        .dv_psum (dv_psum)
    );

    always #5 clk = ~clk;

    // Model: a window is a list of terms of length acc_len+1 fixed at its first beat.
    int          m_sum   [4] = '{0, 0, 0, 0};
    int          m_terms [4] = '{0, 0, 0, 0};
    int          m_win   [4] = '{0, 0, 0, 0};
    bit          m_open  [4] = '{0, 0, 0, 0};
    logic [95:0] exp_psum = 96'd0;
    logic [3:0]  exp_dv = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_sum[i] = 0; m_terms[i] = 0; m_win[i] = 0; m_open[i] = 0;
            end
            exp_psum = 96'd0;
            exp_dv   = 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int p;
                p = int'(prod[i*16 +: 16]);
                exp_dv[i] = 1'b0;
                if (dv_prod[i]) begin
                    if (!m_open[i]) begin
                        m_open[i]  = 1;
                        m_win[i]   = int'(acc_len) + 1;
                        m_sum[i]   = p;
                        m_terms[i] = 1;
                    end else begin
                        m_sum[i]   = m_sum[i] + p;
                        m_terms[i] = m_terms[i] + 1;
                    end
                    if (m_terms[i] == m_win[i] || flush) begin
                        exp_psum[i*24 +: 24] = 24'(m_sum[i]);
                        exp_dv[i] = 1'b1;
                        m_open[i] = 0;
                    end
                end else if (flush && m_open[i]) begin
                    exp_psum[i*24 +: 24] = 24'(m_sum[i]);
                    exp_dv[i] = 1'b1;
                    m_open[i] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    int got_q [4][$];

    // Every-cycle comparison against the model; also logs DUT emits per lane.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dv_lane%0d", i), 32'(dv_psum[i]), 32'(exp_dv[i]));
            check($sformatf("psum_lane%0d", i), 32'(psum[i*24 +: 24]), 32'(exp_psum[i*24 +: 24]));
            if (dv_psum[i] === 1'b1) got_q[i].push_back(int'(psum[i*24 +: 24]));
        end
    end

    task automatic step(input logic [3:0] dv, input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3, input logic fl);
        dv_prod = dv;
        prod    = {p3, p2, p1, p0};
        flush   = fl;
        @(negedge clk);
        dv_prod = 4'd0;
        prod    = 64'd0;
        flush   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal check of what a lane emitted since the last clear (up to two values).
    task automatic check_emits(input string name, input int lane, input int n, input int v0, input int v1);
        #1;
        check({name, "_count"}, 32'(got_q[lane].size()), 32'(n));
        if (n > 0 && got_q[lane].size() > 0) check({name, "_v0"}, 32'(got_q[lane][0]), 32'(v0));
        if (n > 1 && got_q[lane].size() > 1) check({name, "_v1"}, 32'(got_q[lane][1]), 32'(v1));
        $display("scenario %s lane%0d emits=%0d", name, lane, got_q[lane].size());
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) got_q[i].delete();
    endtask

    initial begin
        idle(2);
        #1;
        check("reset_psum", 32'(psum != 96'd0), 32'd0);
        check("reset_dv", 32'(dv_psum), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic window
        acc_len = 8'd3;
        step(4'b0001, 16'd10, 0, 0, 0, 0);
        step(4'b0001, 16'd20, 0, 0, 0, 0);
        step(4'b0001, 16'd30, 0, 0, 0, 0);
        step(4'b0001, 16'd40, 0, 0, 0, 0);
        idle(2);
        check_emits("basic", 0, 1, 100, 0);
        check_emits("basic_l1", 1, 0, 0, 0);
        clear_q();

        // Gaps and independence
        acc_len = 8'd1;
        step(4'b0110, 0, 16'd1, 16'd5, 0, 0);
        step(4'b0010, 0, 16'd2, 0, 0, 0);
        step(4'b0010, 0, 16'd3, 0, 0, 0);
        step(4'b0010, 0, 16'd4, 0, 0, 0);
        step(4'b0100, 0, 0, 16'd7, 0, 0);
        idle(2);
        check_emits("gap_l1", 1, 2, 3, 7);
        check_emits("gap_l2", 2, 1, 12, 0);
        clear_q();

        // Max range
        acc_len = 8'd255;
        for (int k = 0; k < 256; k++) step(4'b1111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
        idle(2);
        check_emits("max_l0", 0, 1, 24'hFFFF00, 0);
        check_emits("max_l3", 3, 1, 24'hFFFF00, 0);
        clear_q();

        // Flush with same-cycle valid, then a new window closed by a bare flush
        acc_len = 8'd7;
        step(4'b1000, 0, 0, 0, 16'd100, 0);
        step(4'b1000, 0, 0, 0, 16'd200, 0);
        step(4'b1000, 0, 0, 0, 16'd300, 1);
        step(4'b1000, 0, 0, 0, 16'd50, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        idle(2);
        check_emits("flush_l3", 3, 2, 600, 50);
        check_emits("flush_l0", 0, 0, 0, 0);
        clear_q();

        // acc_len change mid-window
        acc_len = 8'd2;
        step(4'b0001, 16'd1, 0, 0, 0, 0);
        acc_len = 8'd0;
        step(4'b0001, 16'd1, 0, 0, 0, 0);
        step(4'b0001, 16'd1, 0, 0, 0, 0);
        step(4'b0001, 16'd9, 0, 0, 0, 0);
        idle(2);
        check_emits("len_chg", 0, 2, 3, 9);
        clear_q();

        // Reset mid-window
        acc_len = 8'd3;
        step(4'b0001, 16'd8, 0, 0, 0, 0);
        step(4'b0001, 16'd8, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_psum", 32'(psum != 96'd0), 32'd0);
        check("async_rst_dv", 32'(dv_psum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        for (int k = 0; k < 4; k++) step(4'b0001, 16'd1, 0, 0, 0, 0);
        idle(2);
        check_emits("post_rst", 0, 1, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
